// File: rtl/br_resolve.sv
// Branch resolution and bimodal prediction for the RV32I EX stage.
// Decides conditional branches, redirects fetch on a mispredict, flushes two stages, keeps statistics.
module br_resolve #(
  parameter int BHT_ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  input  logic        i_ex_valid,
  input  logic        i_ex_branch,
  input  logic        i_ex_jump,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic [31:0] o_taken_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic [1:0]  bht_d [BHT_ENTRIES];
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [31:0]      fallthrough_pc;
  logic             legal_br;
  logic             cond_taken;
  logic             resolve;
  logic             actual_taken;
  logic             mispredict;
  logic             unused_if_pc;

  assign if_idx         = i_if_pc[IDX_W+1:2];
  assign ex_idx         = i_ex_pc[IDX_W+1:2];
  assign fallthrough_pc = i_ex_pc + 32'd4;
  assign unused_if_pc   = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign o_pred_taken = bht_q[if_idx][1];
  assign o_br_un      = i_ex_funct3[1];

  always_comb begin
    legal_br   = (i_ex_funct3[2:1] != 2'b01);
    cond_taken = 1'b0;
    case (i_ex_funct3)
      3'b000:         cond_taken = i_br_equal;
      3'b001:         cond_taken = !i_br_equal;
      3'b100, 3'b110: cond_taken = i_br_less;
      3'b101, 3'b111: cond_taken = !i_br_less;
      default:        cond_taken = 1'b0;
    endcase
    resolve      = i_ex_valid && (state_q == IDLE) &&
                   (i_ex_jump || (i_ex_branch && legal_br));
    actual_taken = i_ex_jump || cond_taken;
    mispredict   = resolve && (actual_taken != i_ex_pred_taken);
  end

  always_comb begin
    bht_d         = bht_q;
    redirect_pc_d = redirect_pc_q;
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    // Only conditional branches train the table; jumps would pollute it.
    if (resolve && !i_ex_jump) begin
      if (cond_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
    if (resolve && actual_taken) taken_cnt_d = taken_cnt_q + 32'd1;
    if (mispredict) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
      redirect_pc_d = actual_taken ? i_ex_target : fallthrough_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      redirect_pc_q <= 32'd0;
      taken_cnt_q   <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      bht_q         <= bht_d;
      redirect_pc_q <= redirect_pc_d;
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mispredict) state_d = FLUSH1;
      FLUSH1:  state_d = FLUSH2;
      FLUSH2:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_redirect = (state_q == FLUSH1);
    o_flush    = (state_q == FLUSH1) || (state_q == FLUSH2);
  end

  assign o_redirect_pc = redirect_pc_q;
  assign o_taken_cnt   = taken_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: hand vectors, corner sequences and a random run
// against a cycle-level reference model.
module tb_br_resolve;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic        i_ex_valid, i_ex_branch, i_ex_jump;
  logic [2:0]  i_ex_funct3;
  logic [31:0] i_ex_pc, i_ex_target;
  logic        i_ex_pred_taken;
  logic        o_br_un;
  logic        i_br_less, i_br_equal;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush;
  logic [31:0] o_taken_cnt, o_mispred_cnt;

  always #5 i_clk = ~i_clk;

  br_resolve #(.BHT_ENTRIES(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_if_pc(i_if_pc), .o_pred_taken(o_pred_taken),
    .i_ex_valid(i_ex_valid), .i_ex_branch(i_ex_branch), .i_ex_jump(i_ex_jump),
    .i_ex_funct3(i_ex_funct3), .i_ex_pc(i_ex_pc), .i_ex_target(i_ex_target),
    .i_ex_pred_taken(i_ex_pred_taken), .o_br_un(o_br_un), .i_br_less(i_br_less),
    .i_br_equal(i_br_equal), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_flush(o_flush), .o_taken_cnt(o_taken_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  typedef struct {
    logic        reset, valid, branch, jump;
    logic [2:0]  funct3;
    logic [31:0] pc, target;
    logic        pred, less, equal;
    logic [31:0] if_pc;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        exp_br_un, exp_redirect, exp_flush, exp_pred_after;
    logic [31:0] exp_rpc, exp_taken, exp_mispred;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain counters and an integer history array.
  int          m_bht [16];
  logic [31:0] m_taken, m_mispred, m_rpc;
  int          m_flush_left;
  bit          m_redirect;
  bit          m_known = 0;

  function automatic int midx(logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit model_legal(logic [2:0] f);
    return (f == 3'd0) || (f == 3'd1) || (f >= 3'd4);
  endfunction

  function automatic bit model_taken(stim_t s);
    if (s.jump) return 1'b1;
    case (s.funct3)
      3'd0:       return s.equal;
      3'd1:       return !s.equal;
      3'd4, 3'd6: return s.less;
      3'd5, 3'd7: return !s.less;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic stim_t br(logic valid, logic branch, logic jump, logic [2:0] f3,
                               logic [31:0] pc, logic [31:0] tgt, logic pred,
                               logic less, logic equal);
    stim_t s;
    s.reset = 1'b0; s.valid = valid; s.branch = branch; s.jump = jump; s.funct3 = f3;
    s.pc = pc; s.target = tgt; s.pred = pred; s.less = less; s.equal = equal; s.if_pc = pc;
    return s;
  endfunction

  function automatic vec_t mkvec(stim_t s, logic br_un, logic redir, logic flush,
                                 logic [31:0] rpc, logic [31:0] tk, logic [31:0] mis,
                                 logic pred_after);
    vec_t v;
    v.s = s; v.exp_br_un = br_un; v.exp_redirect = redir; v.exp_flush = flush;
    v.exp_rpc = rpc; v.exp_taken = tk; v.exp_mispred = mis; v.exp_pred_after = pred_after;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (m_known) begin
      check("redirect", {31'd0, o_redirect}, {31'd0, m_redirect});
      check("redirect_pc", o_redirect_pc, m_rpc);
      check("flush", {31'd0, o_flush}, (m_flush_left > 0) ? 32'd1 : 32'd0);
      check("taken_cnt", o_taken_cnt, m_taken);
      check("mispred_cnt", o_mispred_cnt, m_mispred);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bit ev, tk, mis;
    int ix;
    i_reset = s.reset; i_ex_valid = s.valid; i_ex_branch = s.branch; i_ex_jump = s.jump;
    i_ex_funct3 = s.funct3; i_ex_pc = s.pc; i_ex_target = s.target;
    i_ex_pred_taken = s.pred; i_br_less = s.less; i_br_equal = s.equal; i_if_pc = s.if_pc;
    #1;
    if (!s.reset && m_known) begin
      check("br_un", {31'd0, o_br_un}, {31'd0, s.funct3[1]});
      check("pred_taken", {31'd0, o_pred_taken}, (m_bht[midx(s.if_pc)] >= 2) ? 32'd1 : 32'd0);
    end
    @(posedge i_clk);
    if (s.reset) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_taken = 0; m_mispred = 0; m_rpc = 0; m_flush_left = 0; m_redirect = 0; m_known = 1;
    end else begin
      ev  = s.valid && (m_flush_left == 0) && (s.jump || (s.branch && model_legal(s.funct3)));
      tk  = model_taken(s);
      mis = ev && (tk != s.pred);
      ix  = midx(s.pc);
      if (ev && !s.jump) m_bht[ix] = tk ? ((m_bht[ix] < 3) ? m_bht[ix] + 1 : 3)
                                         : ((m_bht[ix] > 0) ? m_bht[ix] - 1 : 0);
      if (ev && tk) m_taken = m_taken + 32'd1;
      if (mis) begin
        m_mispred = m_mispred + 32'd1;
        m_rpc = tk ? s.target : s.pc + 32'd4;
      end
      m_flush_left = mis ? 2 : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
      m_redirect = (m_flush_left == 2);
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(br(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0));
  endtask

  task automatic doReset(input int n);
    stim_t s;
    s = br(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    s.reset = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus(s);
  endtask

  task automatic checkAllWeak(input string tag);
    for (int i = 0; i < 16; i++) begin
      i_if_pc = 32'(i * 4);
      #1;
      check($sformatf("%s_pred%0d", tag, i), {31'd0, o_pred_taken}, 32'd0);
    end
  endtask

  vec_t        vecs [10];
  logic [31:0] t0, mp0;
  stim_t       rs;

  initial begin
    vecs[0] = mkvec(br(1,1,0,3'd4,32'h100,32'h200,0,1,0),       0,1,1,32'h200,1,1,1);
    vecs[1] = mkvec(br(1,1,0,3'd7,32'h104,32'h250,0,1,0),       1,0,0,32'h200,1,1,0);
    vecs[2] = mkvec(br(1,1,0,3'd7,32'h104,32'h250,0,1,0),       1,0,0,32'h200,1,1,0);
    vecs[3] = mkvec(br(1,1,0,3'd7,32'h104,32'h300,0,0,0),       1,1,1,32'h300,2,2,0);
    vecs[4] = mkvec(br(1,1,0,3'd1,32'hFFFFFFFC,32'h700,1,0,1),  0,1,1,32'h0,2,3,0);
    vecs[5] = mkvec(br(1,0,1,3'd0,32'h100,32'h400,0,0,0),       0,1,1,32'h400,3,4,1);
    vecs[6] = mkvec(br(1,1,0,3'd2,32'h104,32'h800,1,1,0),       1,0,0,32'h400,3,4,0);
    vecs[7] = mkvec(br(1,1,1,3'd0,32'h108,32'h500,1,0,0),       0,0,0,32'h400,4,4,0);
    vecs[8] = mkvec(br(1,1,0,3'd0,32'h108,32'h600,1,0,1),       0,0,0,32'h400,5,4,1);
    vecs[9] = mkvec(br(0,1,0,3'd0,32'h108,32'h900,0,0,1),       0,0,0,32'h400,5,4,1);

    doReset(2);
    check("rst_flush", {31'd0, o_flush}, 32'd0);
    check("rst_redirect", {31'd0, o_redirect}, 32'd0);
    check("rst_taken", o_taken_cnt, 32'd0);
    check("rst_mispred", o_mispred_cnt, 32'd0);
    checkAllWeak("rst");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].s);
      check($sformatf("vec%0d_redirect", i), {31'd0, o_redirect}, {31'd0, vecs[i].exp_redirect});
      check($sformatf("vec%0d_flush", i), {31'd0, o_flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("vec%0d_rpc", i), o_redirect_pc, vecs[i].exp_rpc);
      check($sformatf("vec%0d_taken", i), o_taken_cnt, vecs[i].exp_taken);
      check($sformatf("vec%0d_mispred", i), o_mispred_cnt, vecs[i].exp_mispred);
      check($sformatf("vec%0d_pred_after", i), {31'd0, o_pred_taken}, {31'd0, vecs[i].exp_pred_after});
      i_ex_funct3 = vecs[i].s.funct3;
      #1;
      check($sformatf("vec%0d_br_un", i), {31'd0, o_br_un}, {31'd0, vecs[i].exp_br_un});
      if (vecs[i].exp_flush) begin
        applyStimulus(br(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0));
        check($sformatf("vec%0d_flush2", i), {31'd0, o_flush}, 32'd1);
        check($sformatf("vec%0d_redirect2", i), {31'd0, o_redirect}, 32'd0);
        idle(1);
        check($sformatf("vec%0d_flush_end", i), {31'd0, o_flush}, 32'd0);
      end
    end

    // EX contents during both flush cycles must be squashed; resolution resumes afterwards.
    applyStimulus(br(1, 1, 0, 3'd4, 32'h10C, 32'hA00, 0, 1, 0));
    t0 = m_taken; mp0 = m_mispred;
    applyStimulus(br(1, 1, 0, 3'd0, 32'h110, 32'hB00, 1, 0, 1));
    check("flush_ign1_taken", o_taken_cnt, t0);
    check("flush_ign1_mispred", o_mispred_cnt, mp0);
    applyStimulus(br(1, 1, 0, 3'd0, 32'h110, 32'hB00, 1, 0, 1));
    check("flush_ign2_taken", o_taken_cnt, t0);
    check("flush_ign2_flush", {31'd0, o_flush}, 32'd0);
    applyStimulus(br(1, 1, 0, 3'd0, 32'h110, 32'hB00, 1, 0, 1));
    check("resume_taken", o_taken_cnt, t0 + 32'd1);

    // Same-index lookup and update in one cycle: lookup sees the old counter.
    rs = br(1, 1, 0, 3'd0, 32'h120, 32'hC00, 0, 0, 1);
    i_reset = 0; i_ex_valid = 0; i_if_pc = rs.pc;
    #1;
    check("collide_pre", {31'd0, o_pred_taken}, 32'd0);
    applyStimulus(rs);
    check("collide_post", {31'd0, o_pred_taken}, 32'd1);
    idle(2);

    applyStimulus(br(1, 1, 0, 3'd4, 32'h130, 32'hD00, 0, 1, 0));
    check("midflush_in_flush1", {31'd0, o_flush}, 32'd1);
    rs = br(1, 1, 0, 3'd0, 32'h104, 32'hE00, 0, 0, 1);
    rs.reset = 1'b1;
    applyStimulus(rs);
    check("midflush_flush", {31'd0, o_flush}, 32'd0);
    check("midflush_redirect", {31'd0, o_redirect}, 32'd0);
    check("midflush_rpc", o_redirect_pc, 32'd0);
    check("midflush_taken", o_taken_cnt, 32'd0);
    check("midflush_mispred", o_mispred_cnt, 32'd0);
    checkAllWeak("midflush");
    applyStimulus(br(1, 1, 0, 3'd0, 32'h104, 32'hE00, 0, 0, 1));
    check("midflush_weak_to_taken", {31'd0, o_pred_taken}, 32'd1);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      rs.reset  = ($urandom_range(0, 79) == 0);
      rs.valid  = ($urandom_range(0, 3) != 0);
      rs.branch = ($urandom_range(0, 3) != 0);
      rs.jump   = ($urandom_range(0, 5) == 0);
      rs.funct3 = 3'($urandom_range(0, 7));
      rs.pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFF_FFFC);
      rs.target = $urandom;
      rs.pred   = $urandom_range(0, 1) == 1;
      rs.less   = $urandom_range(0, 1) == 1;
      rs.equal  = $urandom_range(0, 1) == 1;
      rs.if_pc  = ($urandom_range(0, 1) == 1) ? rs.pc : $urandom;
      applyStimulus(rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
